instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the team_03 RISC-V core. It sits directly downstream of the `pc` block. It takes the current PC, reads the instruction word over a request/acknowledge memory port, and holds it for decode. Once decode accepts the word, it raises `i_request` to the `pc` block for one cycle so the PC advances. It supports flush on redirect, a misaligned-PC fault and a memory-timeout fault.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: number of REQ cycles without `mem_ack` before a timeout fault.
- `NOP_INSTR`, default 32'h00000013: value of `instr_out` at reset (`addi x0,x0,0`).

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  global enable, same signal as `pc.en`. Low: all registers hold and `i_request` is 0.
- `pc_in`  in  32  current PC, from `pc.pc_out`.
- `flush`  in  1  redirect or branch taken; discard any in-flight or held instruction.
- `decode_ready`  in  1  decode can accept the held instruction.
- `mem_ack`  in  1  memory returns `mem_rdata` this cycle.
- `mem_rdata`  in  32  instruction word from memory.
- `mem_req`  out  1  read request, held high until `mem_ack`.
- `mem_addr`  out  32  read address, stable while `mem_req` is high.
- `instr_out`  out  32  held instruction word.
- `instr_pc`  out  32  address `instr_out` was fetched from.
- `instr_valid`  out  1  `instr_out`/`instr_pc` are valid.
- `i_request`  out  1  one-cycle pulse to `pc.i_request`; the PC may advance.
- `misalign_fault`  out  1  sticky; `pc_in[1:0]` was nonzero at fetch start.
- `timeout_fault`  out  1  sticky; memory did not ack within `TIMEOUT_CYCLES`.

## Operation
- States: IDLE, REQ, HOLD, DRAIN. Reset state is IDLE.
- IDLE:
  - If `en`, no fault set, and `flush`=0: if `pc_in[1:0]`≠0, set `misalign_fault` and stay in IDLE. Otherwise latch `mem_addr`←`pc_in`, clear the timeout counter, and go to REQ.
  - While either fault is set, IDLE never leaves. Only reset clears faults.
- REQ (`mem_req`=1):
  - `mem_ack`&`flush`: discard the data, go to IDLE.
  - `mem_ack` only: `instr_out`←`mem_rdata`, `instr_pc`←`mem_addr`, go to HOLD.
  - `flush` only: go to DRAIN.
  - Otherwise increment the 8-bit counter. When it reaches `TIMEOUT_CYCLES`, set `timeout_fault`, drop `mem_req`, and go to IDLE.
- HOLD (`instr_valid`=1):
  - `flush` has priority: go to IDLE with no `i_request`.
  - Else if `decode_ready`: `i_request`=1 combinationally this cycle, go to IDLE.
  - Else hold, with all outputs stable.
- DRAIN: `mem_req` stays 1 with the same `mem_addr`. On `mem_ack`, discard the data and go to IDLE. `flush` is ignored.
- `i_request` = (state==HOLD) & `decode_ready` & ~`flush` & `en`.
- `instr_valid` = (state==HOLD).
- `mem_req` = (state==REQ) | (state==DRAIN).
- `mem_addr`, `instr_out` and `instr_pc` keep their last values outside the states that drive them.
- No arithmetic on the PC in this block; the PC increment belongs to the `pc` block.

## Timing
- Reset values: `mem_req` 0, `mem_addr` 0, `instr_out` `NOP_INSTR`, `instr_pc` 0, `instr_valid` 0, `i_request` 0, both faults 0, counter 0.
- Latency:
  - IDLE→REQ takes 1 cycle.
  - A same-cycle ack makes `instr_valid` high the next cycle.
  - Zero-wait memory with `decode_ready`=1 gives 1 instruction per 3 cycles.
- `pc` samples `i_request` on the same edge that returns this block to IDLE. `pc_in` is therefore updated when IDLE next samples it.
- `en`=0 in any state: state, counter and outputs freeze. `mem_req` stays asserted in REQ/DRAIN; a `mem_ack` that arrives while `en`=0 is ignored, so memory must hold its ack until `en` returns.
- Reset mid-REQ: `mem_req` drops immediately (asynchronous). Memory must tolerate the abandoned request.
- Timeout fires on the cycle the counter equals `TIMEOUT_CYCLES` with no ack. An ack in that same cycle wins and no fault is set.

## Test plan
- Zero-wait fetch: `pc_in`=0x100, `mem_ack` on the first REQ cycle, `mem_rdata`=0x00500093, `decode_ready`=1. Required: `instr_valid` on cycle 3 with `instr_pc`=0x100, `i_request` a 1-cycle pulse, next `mem_addr`=0x104 after the PC advances.
- Wait states and backpressure: ack after 4 cycles, `decode_ready` low for 3 cycles. Required: `mem_addr` stable while waiting, `instr_out` stable in HOLD, exactly one `i_request` pulse.
- Flush cases:
  - `flush` in HOLD with `decode_ready`=1: no `i_request`, `instr_valid` drops the next cycle.
  - `flush` in REQ without ack: `mem_req` stays high until ack, the data is discarded, `instr_valid` is never asserted.
- Misaligned PC: `pc_in`=0x102. Required: `misalign_fault`=1, `mem_req` never asserted, and the block stays idle until reset.
- Timeout: `TIMEOUT_CYCLES`=4, no ack. Required: `timeout_fault` set after 4 REQ cycles, `mem_req`=0 the next cycle. Then reset mid-REQ: all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Memory read port between instr_fetch and instruction memory.
//   mem_req   : read request, held high until mem_ack
//   mem_addr  : read address, stable while mem_req is high
//   mem_ack   : memory returns mem_rdata this cycle
//   mem_rdata : instruction word from memory
// master = fetch stage side, slave = memory side.
interface instr_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads the word at pc_in over a req/ack memory
// port, holds it for decode and pulses i_request to the pc block once
// decode takes it. Handles flush, misaligned-PC fault and memory timeout.
// Ports:
//   clock, reset     : clock, asynchronous active-high reset
//   en               : global enable; low freezes all state
//   pc_in            : current PC from the pc block
//   flush            : redirect; discard in-flight or held instruction
//   decode_ready     : decode accepts the held instruction
//   mem              : memory read port (instr_fetch_if.master)
//   instr_out/instr_pc/instr_valid : held instruction, its address, valid
//   i_request        : one-cycle pulse, PC may advance
//   misalign_fault, timeout_fault  : sticky faults, cleared only by reset
module instr_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic [31:0]          pc_in,
  input  logic                 flush,
  input  logic                 decode_ready,
  instr_fetch_if.master        mem,
  output logic [31:0]          instr_out,
  output logic [31:0]          instr_pc,
  output logic                 instr_valid,
  output logic                 i_request,
  output logic                 misalign_fault,
  output logic                 timeout_fault
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        mis_q, mis_d;
  logic        to_q, to_d;
  logic [7:0]  cnt_inc;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    mis_d   = mis_q;
    to_d    = to_q;
    cnt_inc = cnt_q + 8'd1;

    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (!mis_q && !to_q && !flush) begin
            if (pc_in[1:0] != 2'b00) begin
              mis_d = 1'b1;
            end else begin
              addr_d  = pc_in;
              cnt_d   = '0;
              state_d = REQ;
            end
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            if (flush) begin
              state_d = IDLE;
            end else begin
              instr_d = mem.mem_rdata;
              ipc_d   = addr_q;
              state_d = HOLD;
            end
          end else if (flush) begin
            state_d = DRAIN;
          end else begin
            // Fault fires on the no-ack cycle that brings the count to the
            // limit, so TIMEOUT_CYCLES REQ cycles elapse before giving up.
            cnt_d = cnt_inc;
            if (cnt_inc == TIMEOUT_V) begin
              to_d    = 1'b1;
              state_d = IDLE;
            end
          end
        end
        HOLD: begin
          if (flush || decode_ready) begin
            state_d = IDLE;
          end
        end
        DRAIN: begin
          // Request already on the bus must complete; its data is dropped.
          if (mem.mem_ack) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
    end
  end

  assign mem.mem_req    = (state_q == REQ) || (state_q == DRAIN);
  assign mem.mem_addr   = addr_q;
  assign instr_out      = instr_q;
  assign instr_pc       = ipc_q;
  assign instr_valid    = (state_q == HOLD);
  assign i_request      = (state_q == HOLD) && decode_ready && !flush && en;
  assign misalign_fault = mis_q;
  assign timeout_fault  = to_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed test-plan scenarios followed by random
// stimulus, all checked against a transaction-level reference model.
module tb_instr_fetch;
  localparam int unsigned TO  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        en, flush, decode_ready;
  logic [31:0] pc_in;
  logic [31:0] instr_out, instr_pc;
  logic        instr_valid, i_request, misalign_fault, timeout_fault;

  instr_fetch_if mem_bus ();

  instr_fetch #(.TIMEOUT_CYCLES(TO), .NOP_INSTR(NOP)) dut (
    .clock          (clock),
    .reset          (reset),
    .en             (en),
    .pc_in          (pc_in),
    .flush          (flush),
    .decode_ready   (decode_ready),
    .mem            (mem_bus.master),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .i_request      (i_request),
    .misalign_fault (misalign_fault),
    .timeout_fault  (timeout_fault)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: what the fetch stage has outstanding, in plain terms.
  bit          m_outstanding;  // a read is on the bus awaiting ack
  bit          m_discard;      // that read was flushed; its data is dropped
  bit          m_have;         // an instruction is held for decode
  int unsigned m_wait;         // no-ack cycles of the live read
  bit          m_mis, m_to;
  logic [31:0] m_addr, m_instr, m_ipc;
  logic [31:0] pc;             // emulated pc block

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_outstanding = 0; m_discard = 0; m_have = 0; m_wait = 0;
    m_mis = 0; m_to = 0;
    m_addr = '0; m_instr = NOP; m_ipc = '0;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   {31'd0, mem_bus.mem_req}, 32'd0);
    check({tag, "_addr"},  mem_bus.mem_addr, 32'd0);
    check({tag, "_instr"}, instr_out, NOP);
    check({tag, "_ipc"},   instr_pc, 32'd0);
    check({tag, "_flags"}, {28'd0, instr_valid, i_request, misalign_fault, timeout_fault}, 32'd0);
  endtask

  // Synchronous-phase reset; leaves time at posedge+1.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    en = 1'b0; flush = 1'b0; decode_ready = 1'b0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    #1 check_reset_values("rst");
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // One cycle: apply inputs, compare outputs, advance model at the edge.
  task automatic step(input bit i_en, input bit i_fl, input bit i_dr,
                      input bit i_ack, input logic [31:0] i_rd);
    bit exp_ireq;
    en = i_en; flush = i_fl; decode_ready = i_dr;
    mem_bus.mem_ack = i_ack; mem_bus.mem_rdata = i_rd; pc_in = pc;
    #2;
    exp_ireq = m_have && i_dr && !i_fl && i_en;
    check("mem_req",   {31'd0, mem_bus.mem_req}, {31'd0, m_outstanding});
    check("mem_addr",  mem_bus.mem_addr, m_addr);
    check("instr_out", instr_out, m_instr);
    check("instr_pc",  instr_pc, m_ipc);
    check("valid",     {31'd0, instr_valid}, {31'd0, m_have});
    check("i_request", {31'd0, i_request}, {31'd0, exp_ireq});
    check("faults",    {30'd0, misalign_fault, timeout_fault}, {30'd0, m_mis, m_to});
    @(posedge clock);
    if (i_en) begin
      if (m_have) begin
        if (i_fl || i_dr) m_have = 0;
      end else if (m_outstanding) begin
        if (i_ack) begin
          m_outstanding = 0;
          if (!m_discard && !i_fl) begin
            m_have = 1; m_instr = i_rd; m_ipc = m_addr;
          end
          m_discard = 0;
        end else if (!m_discard) begin
          if (i_fl) m_discard = 1;
          else begin
            m_wait++;
            if (m_wait == TO) begin m_to = 1; m_outstanding = 0; end
          end
        end
      end else if (!m_mis && !m_to && !i_fl) begin
        if (pc[1:0] != 2'b00) m_mis = 1;
        else begin m_addr = pc; m_wait = 0; m_outstanding = 1; end
      end
      if (exp_ireq) pc = pc + 32'd4;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 0; flush = 0; decode_ready = 0; pc = '0; pc_in = '0;
    mem_bus.mem_ack = 0; mem_bus.mem_rdata = '0;
    model_reset();
    #1 check_reset_values("por");
    do_reset();

    // Zero-wait fetch with decode always ready
    pc = 32'h100;
    step(1, 0, 1, 0, 32'h0);
    step(1, 0, 1, 1, 32'h0050_0093);
    step(1, 0, 1, 0, 32'h0);
    check("zw_ipc",   instr_pc, 32'h100);
    check("zw_instr", instr_out, 32'h0050_0093);
    step(1, 0, 1, 0, 32'h0);
    step(1, 0, 1, 0, 32'h0);
    check("zw_next_addr", mem_bus.mem_addr, 32'h104);

    // Wait states and backpressure
    do_reset();
    pc = 32'h40;
    step(1, 0, 0, 0, 32'h0);
    repeat (3) step(1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 1, 32'hDEAD_BEEF);
    repeat (3) step(1, 0, 0, 0, 32'h0);
    step(0, 0, 1, 0, 32'h0);            // enable low: no pulse
    step(1, 0, 1, 0, 32'h0);
    step(1, 0, 1, 0, 32'h0);
    check("bp_pc_advanced", pc, 32'h44);

    // Flush in HOLD, then flush in REQ (drain)
    do_reset();
    pc = 32'h300;
    step(1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 1, 32'h1111_1111);
    step(1, 1, 1, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 1, 32'h2222_2222);
    check("drain_dropped", instr_out, 32'h1111_1111);

    // Misaligned PC
    do_reset();
    pc = 32'h102;
    repeat (4) step(1, 0, 1, 0, 32'h0);
    check("mis_fault", {31'd0, misalign_fault}, 32'd1);
    pc = 32'h200;
    repeat (3) step(1, 0, 1, 1, 32'h0);

    // Timeout with TO=4, then async reset mid-REQ
    do_reset();
    pc = 32'h500;
    step(1, 0, 1, 0, 32'h0);
    repeat (TO) step(1, 0, 1, 0, 32'h0);
    check("to_fault", {31'd0, timeout_fault}, 32'd1);
    repeat (2) step(1, 0, 1, 0, 32'h0);
    do_reset();
    step(1, 0, 1, 0, 32'h0);
    step(1, 0, 1, 0, 32'h0);
    #2 reset = 1'b1;
    #1 check_reset_values("async");
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;

    // Random traffic
    pc = ($urandom & 32'h0000_FFFC);
    for (int i = 0; i < 3000; i++) begin
      bit r_en, r_fl, r_dr, r_ack;
      r_en  = ($urandom_range(0, 9) != 0);
      r_fl  = ($urandom_range(0, 11) == 0);
      r_dr  = ($urandom_range(0, 4) < 3);
      r_ack = m_outstanding && ($urandom_range(0, 9) < 7);
      if (r_fl) begin
        pc = ($urandom & 32'h0000_FFFC);
        if ($urandom_range(0, 19) == 0) pc[0] = 1'b1;
      end
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else if (m_outstanding && $urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        #1 check_reset_values("rnd_async");
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
      end else begin
        step(r_en, r_fl, r_dr, r_ack, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
